// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX write path among NUM_REQ byte producers.
// A grant is held until the message's last byte or MAX_BURST beats, whichever comes first.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 5,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                state_reg;
  logic [IDX_W-1:0]      rr_ptr_reg;
  logic [CNT_WIDTH-1:0]  beat_cnt_reg;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [IDX_W-1:0]      winner_next;
  logic [IDX_W-1:0]      ptr_next;
  logic                  any_valid;
  logic                  beat;
  logic                  release_beat;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[gi] = (state_reg == GRANT) && (grant_id == IDX_W'(gi)) && ready_out;
    end
  endgenerate

  // data_out follows grant_id even outside a grant, so it never carries X.
  assign data_out     = data_arr[grant_id];
  assign valid_out    = (state_reg == GRANT) && req_valid[grant_id];
  assign beat         = valid_out && ready_out;
  assign release_beat = beat && (req_last[grant_id] ||
                                 (beat_cnt_reg == CNT_WIDTH'(MAX_BURST - 1)));
  assign ptr_next     = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

  // Circular search from rr_ptr; scanning downwards lets the nearest candidate win last.
  always_comb begin
    logic [IDX_W:0] cand;
    any_valid   = 1'b0;
    winner_next = rr_ptr_reg;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (req_valid[cand[IDX_W-1:0]]) begin
        any_valid   = 1'b1;
        winner_next = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      grant_id     <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      busy         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            grant_id     <= winner_next;
            beat_cnt_reg <= '0;
            state_reg    <= GRANT;
            busy         <= 1'b1;
          end
        end
        GRANT: begin
          if (beat) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_WIDTH'(1);
            if (release_beat) begin
              state_reg  <= IDLE;
              busy       <= 1'b0;
              rr_ptr_reg <= ptr_next;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requesters replay byte queues, and a message-level
// round-robin model predicts the exact sequence of forwarded bytes and grant releases.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NR-1:0]   req_valid, req_ready, req_last;
  logic [NR*DW-1:0] req_data;
  logic            valid_out, ready_out, busy;
  logic [DW-1:0]   data_out;
  logic [1:0]      grant_id;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0]  src_mem [NR][64];   // {last, data}
  int          head [NR];
  int          tail [NR];
  logic [10:0] exp_q [$];          // {release, grant, data}
  int          model_ptr = 0;
  int          ready_pct = 100;
  int          beats_seen = 0;
  bit          idle_due = 0;
  bit          prev_stall = 0;
  logic [1:0]  prev_gid;
  logic [7:0]  prev_data;
  logic [NR-1:0] fire_mask;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic push_msg(input int r, input int len, input logic [7:0] first,
                          input int stp, input bit rnd);
    for (int j = 0; j < len; j++) begin
      src_mem[r][tail[r]] = {(j == len - 1), (rnd ? 8'($urandom) : 8'(int'(first) + j * stp))};
      tail[r]++;
    end
  endtask

  // Message-level model: pick the first non-empty requester from the pointer, forward
  // its bytes until last or MB bytes, then move the pointer past it.
  task automatic build_expected();
    int h [NR];
    int g;
    int n;
    bit any;
    bit rel;
    logic [8:0] b;
    for (int i = 0; i < NR; i++) h[i] = head[i];
    forever begin
      any = 0;
      g = 0;
      for (int k = NR - 1; k >= 0; k--) begin
        int c;
        c = (model_ptr + k) % NR;
        if (h[c] < tail[c]) begin
          any = 1;
          g = c;
        end
      end
      if (!any) break;
      n = 0;
      forever begin
        b = src_mem[g][h[g]];
        h[g]++;
        n++;
        rel = b[8] || (n == MB);
        exp_q.push_back({rel, 2'(g), b[7:0]});
        if (rel) break;
      end
      model_ptr = (g + 1) % NR;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i] = 1'b1;
        req_last[i]  = src_mem[i][head[i]][8];
        req_data[i*DW +: DW] = src_mem[i][head[i]][7:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
    ready_out = ($urandom_range(99) < ready_pct);
  endtask

  task automatic monitor();
    logic [NR-1:0] exp_ready;
    logic [10:0]   e;
    fire_mask = req_valid & req_ready;
    if (idle_due) begin
      check_val("gap_busy", 32'(busy), 32'(0));
      idle_due = 0;
    end
    if (prev_stall) begin
      check_val("stall_grant", 32'(grant_id), 32'(prev_gid));
      check_val("stall_data", 32'(data_out), 32'(prev_data));
    end
    exp_ready = busy ? (NR'(ready_out) << grant_id) : '0;
    check_val("req_ready", 32'(req_ready), 32'(exp_ready));
    check_val("valid_out", 32'(valid_out), 32'(busy & req_valid[grant_id]));
    if (valid_out && ready_out) begin
      beats_seen++;
      check_val("beat_expected", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("beat", 32'({grant_id, data_out}), 32'(e[9:0]));
        $display("beat req=%0d data=0x%02h release=%0d", grant_id, data_out, e[10]);
        idle_due = e[10];
      end
    end
    prev_stall = valid_out && !ready_out;
    prev_gid   = grant_id;
    prev_data  = data_out;
  endtask

  task automatic step_cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (fire_mask[i]) head[i]++;
    drive_inputs();
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 2000) begin
      step_cycle();
      cyc++;
    end
    check_val({tag, "_drained"}, 32'(exp_q.size()), 32'(0));
    step_cycle();
    step_cycle();
  endtask

  task automatic run_round(input string tag);
    build_expected();
    drive_inputs();
    drain(tag);
    clear_queues();
  endtask

  initial begin
    int start;
    int cyc;
    rstn      = 1'b0;
    req_valid = '1;
    req_last  = '1;
    req_data  = 32'h5C5B5A59;
    ready_out = 1'b1;
    clear_queues();

    // Reset held with every requester valid.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("rst_valid_out", 32'(valid_out), 32'(0));
      check_val("rst_req_ready", 32'(req_ready), 32'(0));
      check_val("rst_busy", 32'(busy), 32'(0));
      check_val("rst_grant_id", 32'(grant_id), 32'(0));
      check_val("rst_data_out", 32'(data_out), 32'h59);
    end

    // Round-robin of single-byte messages, released straight out of reset.
    @(posedge clk);
    #1;
    push_msg(0, 1, 8'hA0, 0, 0);
    push_msg(1, 1, 8'hA1, 0, 0);
    push_msg(2, 1, 8'hA2, 0, 0);
    push_msg(3, 1, 8'hA3, 0, 0);
    push_msg(0, 1, 8'hA0, 0, 0);
    model_ptr = 0;
    ready_pct = 100;
    build_expected();
    drive_inputs();
    rstn = 1'b1;
    check_val("lat_idle_busy", 32'(busy), 32'(0));
    step_cycle();
    check_val("lat_grant_busy", 32'(busy), 32'(1));
    check_val("lat_grant_id", 32'(grant_id), 32'(0));
    drain("rr");
    clear_queues();

    // Message atomicity under backpressure while another requester waits.
    ready_pct = 50;
    push_msg(2, 3, 8'h11, 8'h11, 0);
    push_msg(1, 2, 8'h71, 1, 0);
    run_round("atomic");

    // Burst limit: a 6-byte message is split around a waiting requester.
    push_msg(0, 6, 8'h01, 1, 0);
    push_msg(3, 1, 8'hD3, 0, 0);
    run_round("burst");

    // Randomized message mixes and ready patterns.
    for (int r = 0; r < 10; r++) begin
      ready_pct = $urandom_range(30, 100);
      for (int i = 0; i < NR; i++) begin
        int nm;
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) push_msg(i, $urandom_range(1, 7), 8'h00, 0, 1);
      end
      run_round("rand");
    end

    // Reset in the middle of a 5-byte message.
    ready_pct = 100;
    push_msg(1, 5, 8'hE0, 1, 0);
    build_expected();
    drive_inputs();
    start = beats_seen;
    cyc = 0;
    while (beats_seen < start + 2 && cyc < 50) begin
      step_cycle();
      cyc++;
    end
    check_val("mr_beats", 32'(beats_seen - start), 32'(2));
    rstn = 1'b0;
    exp_q.delete();
    idle_due   = 0;
    prev_stall = 0;
    @(posedge clk);
    #1;
    check_val("mr_busy", 32'(busy), 32'(0));
    check_val("mr_valid_out", 32'(valid_out), 32'(0));
    check_val("mr_grant_id", 32'(grant_id), 32'(0));
    clear_queues();
    drive_inputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_ptr = 0;
    push_msg(2, 2, 8'h5A, 1, 0);
    push_msg(1, 1, 8'h3C, 0, 0);
    run_round("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
